// File: rtl/mcpu_ram_arb.sv
// -----------------------------------------------------------------------------
// mcpu_ram_arb
//
// Single-array RAM controller for the MCPU. A data port (read/write) and an
// instruction-fetch port (read-only) share one memory array. At most one array
// access happens per cycle, chosen by a cycle-level arbiter. Reads are
// registered: rdata/rvalid appear the cycle after the grant edge.
//
// Arbitration: the data port wins a simultaneous request unless the
// instruction port has already been denied STARVE_LIMIT cycles in a row, in
// which case the instruction port is forced to win. Under continuous contention
// this gives STARVE_LIMIT data grants followed by one fetch grant, repeating.
//
// Optional feature (macro MCPU_RAM_CLEAR_EN):
//   defined   - after every reset a CLEAR state walks the whole array writing
//               zero, one address per cycle. busy is high and no grants are
//               given while it runs.
//   undefined - no CLEAR state, busy is tied low, array contents are undefined
//               after power-up and preserved across reset.
//
// Parameters:
//   WORD_SIZE    data word width
//   ADDR_WIDTH   address width, depth = 1 << ADDR_WIDTH
//   STARVE_LIMIT denied fetch cycles before the fetch port is forced (1..15)
//   CNT_WIDTH    width of the saturating contention counter
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   d_req/d_we/d_addr/d_wdata  data-port request, write enable, address, data
//   d_gnt               data-port accepted this cycle (combinational)
//   d_rvalid/d_rdata    registered data-port read result
//   i_req/i_addr        fetch request and address
//   i_gnt               fetch accepted this cycle (combinational)
//   i_rvalid/i_rdata    registered fetch result
//   busy                clear sequence running; no grants
//   conflict_cnt        saturating count of cycles with both ports requesting
// -----------------------------------------------------------------------------
module mcpu_ram_arb #(
    parameter int WORD_SIZE    = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_SIZE-1:0]  d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [WORD_SIZE-1:0]  d_rdata,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [WORD_SIZE-1:0]  i_rdata,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    localparam int         RAM_SIZE   = 1 << ADDR_WIDTH;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

`ifdef MCPU_RAM_CLEAR_EN
    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    typedef enum logic {ST_RUN = 1'b1} state_t;
    localparam state_t RESET_STATE = ST_RUN;
`endif

    // Memory array: no reset so it maps onto block RAM.
    logic [WORD_SIZE-1:0]  r_mem [RAM_SIZE];

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_starve_cnt;
    logic [CNT_WIDTH-1:0]  r_conflict_cnt;
    logic                  r_d_rvalid;
    logic                  r_i_rvalid;
    logic [WORD_SIZE-1:0]  r_d_rdata;
    logic [WORD_SIZE-1:0]  r_i_rdata;
`ifdef MCPU_RAM_CLEAR_EN
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
`endif

    logic                  w_busy;
    logic                  w_clr_we;
    logic                  w_force;
    logic                  w_active;
    logic                  w_d_rd;
    logic                  w_i_rd;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [WORD_SIZE-1:0]  w_mem_wdata;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_clr_we     = 1'b0;
`ifdef MCPU_RAM_CLEAR_EN
        case (r_state)
            ST_CLEAR: begin
                w_busy   = 1'b1;
                w_clr_we = 1'b1;
                if (r_clr_ptr == '1) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN:   w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
`endif
    end

    // ---------------------------------------------------------- arbitration
    // rst_n gates the grants so nothing is accepted while reset is held,
    // even in the build without a clear sequence (where busy is always 0).
    assign w_force  = (r_starve_cnt == STARVE_LIM);
    assign w_active = rst_n & ~w_busy;
    assign d_gnt    = d_req & w_active & ~(w_force & i_req);
    assign i_gnt    = i_req & w_active & (~d_req | w_force);
    assign w_d_rd   = d_gnt & ~d_we;
    assign w_i_rd   = i_gnt;

    // Single write port shared by the clear sequencer and the data port;
    // they can never be active in the same cycle because busy blocks grants.
    always_comb begin
        w_mem_we    = d_gnt & d_we;
        w_mem_addr  = d_addr;
        w_mem_wdata = d_wdata;
`ifdef MCPU_RAM_CLEAR_EN
        if (w_clr_we) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_ptr;
            w_mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------ control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RESET_STATE;
            r_starve_cnt   <= '0;
            r_conflict_cnt <= '0;
            r_d_rvalid     <= 1'b0;
            r_i_rvalid     <= 1'b0;
            r_d_rdata      <= '0;
            r_i_rdata      <= '0;
`ifdef MCPU_RAM_CLEAR_EN
            r_clr_ptr      <= '0;
`endif
        end else begin
            r_state <= w_state_next;
`ifdef MCPU_RAM_CLEAR_EN
            if (w_clr_we) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
`endif
            // Counts consecutive denied fetch cycles; a grant restarts it.
            // It cannot pass STARVE_LIM: at the limit a pending fetch wins.
            if (i_gnt) begin
                r_starve_cnt <= '0;
            end else if (i_req && !w_busy) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            if (d_req && i_req && !w_busy && !(&r_conflict_cnt)) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end

            // rvalid is a one-cycle pulse per granted read; rdata holds.
            r_d_rvalid <= w_d_rd;
            r_i_rvalid <= w_i_rd;
            if (w_d_rd) begin
                r_d_rdata <= r_mem[d_addr];
            end
            if (w_i_rd) begin
                r_i_rdata <= r_mem[i_addr];
            end
        end
    end

    assign d_rvalid     = r_d_rvalid;
    assign d_rdata      = r_d_rdata;
    assign i_rvalid     = r_i_rvalid;
    assign i_rdata      = r_i_rdata;
    assign busy         = w_busy;
    assign conflict_cnt = r_conflict_cnt;

endmodule
